// File: rtl/cnn_pkg.sv
// Shared types and constants for the 4x4 cellular-network array and its readout.
// Cell values are signed fixed point: 1 sign bit, 4 integer bits, 4 fraction bits.
package cnn_pkg;

   localparam int CNN_WIDTH     = 9;
   localparam int CNN_CELLS     = 16;
   localparam int CNN_INT_BITS  = 4;
   localparam int CNN_FRAC_BITS = 4;

   localparam logic [CNN_WIDTH-1:0] CNN_ONE  = 9'h010;
   localparam logic [CNN_WIDTH-1:0] CNN_MONE = 9'h1F0;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_WATCH  = 2'd1,
      RD_STREAM = 2'd2
   } cnn_rd_state_t;

endpackage

// File: rtl/cnn_stable_detect.sv
// Tracks how many consecutive cycles the whole Y bundle has stayed unchanged;
// settled_o is a combinational strobe in the cycle the run reaches STABLE_CYCLES.
module cnn_stable_detect
   import cnn_pkg::*;
#(
   parameter int BUS_W         = CNN_WIDTH * CNN_CELLS,
   parameter int STABLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [BUS_W-1:0] y_i,
   output logic             settled_o
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);

   logic [BUS_W-1:0] prev_q;
   logic [SW-1:0]    stable_q;
   logic [SW-1:0]    stable_d;
   logic             eq;

   assign eq        = (y_i == prev_q);
   assign stable_d  = eq ? stable_q + SW'(1) : '0;
   assign settled_o = en_i & eq & (stable_q == SW'(STABLE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= '0;
         stable_q <= '0;
      end else if (load_i) begin
         prev_q   <= y_i;
         stable_q <= '0;
      end else if (en_i) begin
         prev_q   <= y_i;
         stable_q <= stable_d;
      end
   end

endmodule

// File: rtl/cnn_settle_reader.sv
// Waits for the array outputs to settle (or time out), snapshots all cells in one
// cycle, then streams them one per valid/ready handshake; stream outputs come only from registers.
module cnn_settle_reader
   import cnn_pkg::*;
#(
   parameter int WIDTH         = CNN_WIDTH,
   parameter int CELLS         = CNN_CELLS,
   parameter int STABLE_CYCLES = 4,
   parameter int MAX_CYCLES    = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WIDTH*CELLS-1:0]   y_in,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(CELLS)-1:0] out_index,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic                     converged,
   output logic                     done
);

   localparam int IW = $clog2(CELLS);
   localparam int CW = $clog2(MAX_CYCLES + 1);

   cnn_rd_state_t   state_q;
   logic [IW-1:0]   idx_q;
   logic [IW-1:0]   idx_d;
   logic [CW-1:0]   cyc_q;
   logic [CW-1:0]   cyc_d;
   logic            conv_q;
   logic            done_q;
   logic [WIDTH-1:0] snap_q [CELLS];

   logic settled;
   logic timeout;
   logic is_last;

   cnn_stable_detect #(
      .BUS_W         (WIDTH * CELLS),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_detect (
      .clk       (clk),
      .rst       (rst),
      .load_i    ((state_q == RD_IDLE) && start),
      .en_i      (state_q == RD_WATCH),
      .y_i       (y_in),
      .settled_o (settled)
   );

   assign timeout = (cyc_q == CW'(MAX_CYCLES - 1));
   assign is_last = (idx_q == IW'(CELLS - 1));
   assign idx_d   = idx_q + IW'(1);
   assign cyc_d   = cyc_q + CW'(1);

   // Every output is a decode of registered state; nothing reaches them from y_in.
   assign out_valid = (state_q == RD_STREAM);
   assign out_data  = out_valid ? snap_q[idx_q] : '0;
   assign out_index = idx_q;
   assign out_last  = out_valid & is_last;
   assign busy      = (state_q != RD_IDLE);
   assign converged = conv_q;
   assign done      = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RD_IDLE;
         idx_q   <= '0;
         cyc_q   <= '0;
         conv_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int k = 0; k < CELLS; k++) snap_q[k] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            RD_IDLE: begin
               if (start) begin
                  cyc_q   <= '0;
                  state_q <= RD_WATCH;
               end
            end
            RD_WATCH: begin
               cyc_q <= cyc_d;
               // Settle takes priority when it coincides with the timeout cycle.
               if (settled || timeout) begin
                  for (int k = 0; k < CELLS; k++) snap_q[k] <= y_in[k*WIDTH +: WIDTH];
                  conv_q  <= settled;
                  state_q <= RD_STREAM;
               end
            end
            RD_STREAM: begin
               if (out_ready) begin
                  if (is_last) begin
                     idx_q   <= '0;
                     done_q  <= 1'b1;
                     state_q <= RD_IDLE;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            default: state_q <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_settle_reader.sv
// Randomized bench for cnn_settle_reader: each watch is scored by a window-equality model
// over the driven Y sequence, and each stream word against the predicted snapshot.
module tb_cnn_settle_reader;
   import cnn_pkg::*;

   localparam int W  = 9;
   localparam int C  = 16;
   localparam int SC = 4;
   localparam int MC = 8;
   localparam int BW = W * C;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [BW-1:0] y_in;
   logic [W-1:0]  out_data;
   logic [3:0]    out_index;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          converged;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] snap_exp [C];
   logic         exp_conv;

   cnn_settle_reader #(
      .WIDTH         (W),
      .CELLS         (C),
      .STABLE_CYCLES (SC),
      .MAX_CYCLES    (MC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .y_in      (y_in),
      .out_data  (out_data),
      .out_index (out_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .converged (converged),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW-1:0] rand_bundle();
      logic [BW-1:0] r;
      for (int k = 0; k < C; k++) r[k*W +: W] = W'($urandom_range(0, 511));
      return r;
   endfunction

   function automatic logic [BW-1:0] bump(input logic [BW-1:0] b);
      int           c = $urandom_range(0, C - 1);
      logic [W-1:0] d = W'($urandom_range(1, 511));
      b[c*W +: W] = b[c*W +: W] ^ d;
      return b;
   endfunction

   // Cells 6, 7, 10, 11 (1-based) at +1.0, the rest at -1.0.
   function automatic logic [BW-1:0] pattern_bundle();
      logic [BW-1:0] r;
      for (int k = 1; k <= C; k++)
         r[k*W-1 -: W] = (k == 6 || k == 7 || k == 10 || k == 11) ? CNN_ONE : CNN_MONE;
      return r;
   endfunction

   // Modes: 0 constant pattern, 1 cell 1 toggling, 2 change in cycle 3, else random drift.
   task automatic run_watch(input int mode);
      logic [BW-1:0] v [MC+1];
      logic [BW-1:0] a;
      logic [BW-1:0] b;
      logic [W-1:0]  ta;
      logic [W-1:0]  tb;
      int            e;
      bit            found;
      bit            same;
      case (mode)
         0: for (int k = 0; k <= MC; k++) v[k] = pattern_bundle();
         1: begin
            a  = rand_bundle();
            ta = W'($urandom_range(0, 511));
            tb = ta ^ W'($urandom_range(1, 511));
            for (int k = 0; k <= MC; k++) begin
               v[k] = a;
               v[k][W-1:0] = (k % 2 == 1) ? ta : tb;
            end
         end
         2: begin
            a = rand_bundle();
            b = bump(a);
            for (int k = 0; k <= MC; k++) v[k] = (k < 3) ? a : b;
         end
         default: begin
            v[0] = rand_bundle();
            for (int k = 1; k <= MC; k++)
               v[k] = ($urandom_range(0, 2) == 0) ? bump(v[k-1]) : v[k-1];
         end
      endcase
      // Settled at the first cycle k whose value matches the previous SC values
      // (cycle 0 being the one sampled with start); otherwise timed out at MC.
      found = 1'b0;
      e     = MC;
      for (int k = SC; k <= MC; k++) begin
         if (!found) begin
            same = 1'b1;
            for (int j = 1; j <= SC; j++) if (v[k-j] != v[k]) same = 1'b0;
            if (same) begin
               found = 1'b1;
               e     = k;
            end
         end
      end
      exp_conv = found;
      for (int c = 0; c < C; c++) snap_exp[c] = v[e][c*W +: W];

      start = 1'b1;
      y_in  = v[0];
      tick();
      start = 1'b0;
      for (int k = 1; k <= e; k++) begin
         y_in  = v[k];
         start = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         chk("watch_valid", 32'(out_valid), 0);
         chk("watch_busy", 32'(busy), 1);
         chk("watch_done", 32'(done), 0);
         tick();
         start = 1'b0;
      end
      @(negedge clk);
      chk("valid_rise", 32'(out_valid), 1);
      chk("converged", 32'(converged), 32'(exp_conv));
   endtask

   // Ready modes: 0 always, 1 alternating from 0, else random. rst_idx >= 0 resets there.
   task automatic stream(input int rmode, input int rst_idx);
      int n   = 0;
      int cyc = 0;
      bit rdy;
      bit vld;
      while (n < C && cyc < 400) begin
         vld = out_valid;
         chk("s_valid", 32'(out_valid), 1);
         chk("s_index", 32'(out_index), n);
         chk("s_data", 32'(out_data), 32'(snap_exp[n]));
         chk("s_last", 32'(out_last), 32'(n == C - 1));
         if (n == rst_idx) begin
            rst       = 1'b1;
            out_ready = 1'b0;
            tick();
            rst = 1'b0;
            @(negedge clk);
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_conv", 32'(converged), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_data", 32'(out_data), 0);
            exp_conv = 1'b0;
            return;
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = cyc[0];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         start     = ($urandom_range(0, 3) == 0);
         y_in      = rand_bundle();
         tick();
         start = 1'b0;
         if (rdy && vld) n++;
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      chk("xfer_count", n, C);
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_valid", 32'(out_valid), 0);
      chk("held_conv", 32'(converged), 32'(exp_conv));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      y_in      = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_busy", 32'(busy), 0);
      chk("rst_out_done", 32'(done), 0);
      chk("rst_out_conv", 32'(converged), 0);
      chk("rst_out_index", 32'(out_index), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_last", 32'(out_last), 0);
      rst = 1'b0;
      tick();

      run_watch(0); stream(0, -1);
      repeat (2) tick();
      run_watch(1); stream(1, -1);
      tick();
      run_watch(2); stream(0, -1);
      run_watch(0); stream(1, 7);
      tick();
      run_watch(0); stream(0, -1);
      run_watch(0); stream(2, -1);

      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
         run_watch(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3);
         stream($urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, C - 1)) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn_settle_reader.md
# cnn_settle_reader

Readout block on the output side of the 4x4 cellular-network array. It watches the 16 cell outputs after a run is started, decides when the array has settled (or has run too long), snapshots all 16 values in one cycle, and streams them out one cell per transfer over a valid/ready interface. It sits between the `fourbyfour` Y outputs and whatever consumes results (host interface, display, next layer).

## Interface
- `WIDTH`, 9: cell value width. Data is passed through unchanged and compared bitwise only.
- `CELLS`, 16: number of cells. Cell k (k = 1..CELLS) occupies `y_in[k*WIDTH-1 -: WIDTH]`.
- `STABLE_CYCLES`, 4: consecutive unchanged cycles that count as settled. Legal range is >= 1.
- `MAX_CYCLES`, 255: watch-phase timeout in cycles. Legal range is >= 1.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a watch. Sampled only in IDLE.
- `y_in`, in, WIDTH*CELLS: flat bundle of Y1_out..Y16_out, with Y1 in the LSBs.
- `out_data`, out, WIDTH: the current cell value.
- `out_index`, out, $clog2(CELLS): cell index, 0-based (0 means Y1).
- `out_valid`, out, 1: the current word is available.
- `out_ready`, in, 1: the consumer accepts the word.
- `out_last`, out, 1: the current word is the final cell.
- `busy`, out, 1: high in any state other than IDLE.
- `converged`, out, 1: result status. 1 means settled, 0 means timed out. Valid from STREAM entry until the next start.
- `done`, out, 1: one-cycle pulse after the last transfer.

## Operation
- States: IDLE, WATCH, STREAM.
- IDLE:
  - All outputs are 0, except that `converged` holds its last value.
  - On `start`: load `prev <= y_in`, clear `stable_cnt` and `cyc_cnt`, then go to WATCH.
- WATCH, every cycle:
  - `eq = (y_in == prev)`, compared over the full bundle.
  - `prev <= y_in`, and `cyc_cnt++`.
  - `stable_cnt <= eq ? stable_cnt+1 : 0`.
- Leaving WATCH:
  - Settle condition: `eq` holds and `stable_cnt == STABLE_CYCLES-1`. Then `snap <= y_in`, `converged <= 1`, go to STREAM.
  - Timeout condition: `cyc_cnt == MAX_CYCLES-1` with the settle condition false. Then `snap <= y_in`, `converged <= 0`, go to STREAM.
  - If both conditions hold in the same cycle, settle wins (`converged = 1`).
- STREAM:
  - `out_valid = 1`, `out_data = snap[idx]`, `out_index = idx`, `out_last = (idx == CELLS-1)`.
  - On `out_valid & out_ready`:
    - If not last: `idx++`.
    - If last: `idx <= 0`, pulse `done` for the next cycle, go to IDLE.
  - Snap is frozen. Changes on `y_in` during STREAM have no effect.
- `start` outside IDLE is ignored. `start` asserted in the same cycle that `done` pulses is accepted, because the FSM is already in IDLE.
- Counter widths:
  - `cyc_cnt`: $clog2(MAX_CYCLES+1).
  - `stable_cnt`: $clog2(STABLE_CYCLES+1).
  - Neither counter wraps, because leaving WATCH bounds both.
- `rst` in any state, including mid-stream with `out_valid` high:
  - Next cycle is IDLE.
  - `out_valid`, `busy`, `done`, `converged`, `idx` and all counters are 0.
  - `snap` and `prev` are cleared to 0.

## Timing
- `start` is accepted at edge 0. WATCH occupies cycles 1..N.
- With `y_in` constant, N = STABLE_CYCLES. `out_valid` first rises in cycle STABLE_CYCLES+1, which is cycle 5 by default.
- With `y_in` never settling, `out_valid` rises in cycle MAX_CYCLES+1.
- One word transfers per handshake cycle. With `out_ready` held high, CELLS consecutive cycles are needed.
- `out_data`, `out_index`, `out_last` and `out_valid` are registered or decoded from registers only, with no combinational path from `y_in`.
- They hold stable while `out_valid & !out_ready`.
- `done` is high exactly one cycle, the one after the last handshake. `busy` is low in that same cycle.

## Structure
- Shared package `cnn_pkg` holds:
  - `CNN_WIDTH = 9` and `CNN_CELLS = 16`.
  - Fixed-point constants: 1 sign bit, 4 integer bits, 4 fraction bits; `CNN_ONE = 9'h010`, `CNN_MONE = 9'h1F0`.
  - The state enum `cnn_rd_state_t`.
- One natural sub-module, `cnn_stable_detect`. It contains the prev register, the bundle comparator and `stable_cnt`, and outputs a `settled` strobe. The FSM, snapshot and stream mux stay in the top.

## Test plan
- Constant `y_in` (cells 6, 7, 10, 11 = 9'h010, others 9'h1F0), `start` at cycle 0, `out_ready = 1`:
  - `out_valid` rises at cycle 5 and `converged = 1`.
  - Indices 0..15 appear with matching data, `out_last` at index 15, `done` at cycle 21.
- `y_in` toggling cell 1 every cycle, with `MAX_CYCLES = 8`:
  - `out_valid` rises at cycle 9 and `converged = 0`.
  - The snapshot equals `y_in` as sampled in cycle 8.
- `y_in` changes in cycle 3, then holds:
  - The stable count restarts, and `out_valid` rises at cycle 8 rather than 5.
- Backpressure: `out_ready` alternates 0/1 starting at 0, and `y_in` is scrambled during STREAM:
  - Each index is held until accepted, and the data is unchanged from the snapshot.
  - Exactly 16 transfers occur.
- `rst` asserted at index 7 mid-stream:
  - Next cycle `out_valid = 0`, `busy = 0`, `converged = 0`.
  - A following `start` restores the full 16-word sequence from index 0.
- `start` pulsed during WATCH and STREAM is ignored. `start` in the `done` cycle begins a new watch, with `out_valid` at `done`+5.
